// File: rtl/wb_gpio_master.sv
// -----------------------------------------------------------------------------
// wb_gpio_master
// Wishbone classic single-transfer master for the GPIO slave register map.
// Host commands are queued in a small FIFO. One bus transfer is issued at a
// time, and its result is returned through a valid/ready response channel.
//
// Optional build macro: WB_GPIO_MASTER_TIMEOUT_EN
//   When this macro is defined, a bus transfer that sees no ack within
//   TIMEOUT_CYC cycles completes with rsp_err = 1. When it is undefined, the
//   master waits for ack indefinitely and rsp_err stays 0.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_we/cmd_type/cmd_port/cmd_reg/cmd_dat : host command
//   rsp_valid/rsp_ready/rsp_dat/rsp_we/rsp_err                  : host response
//   ma_dat_o/ma_sel_o/ma_addr_o/ma_stb_o/ma_cyc_o/ma_we_o        : Wishbone out
//   ma_dat_i/ma_ack_i                                            : Wishbone in
// -----------------------------------------------------------------------------
module wb_gpio_master #(
   parameter int DATA_WIDTH      = 32,
   parameter int SEL_WIDTH       = 4,
   parameter int ADDR_TYPE_WIDTH = 5,
   parameter int ADDR_PORT_WIDTH = 5,
   parameter int ADDR_REG_WIDTH  = 5,
   parameter int ADDR_WIDTH      = ADDR_TYPE_WIDTH + ADDR_PORT_WIDTH + ADDR_REG_WIDTH,
   parameter int CMD_DEPTH       = 4,
   parameter int TIMEOUT_CYC     = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_we,
   input  logic [ADDR_TYPE_WIDTH-1:0] cmd_type,
   input  logic [ADDR_PORT_WIDTH-1:0] cmd_port,
   input  logic [ADDR_REG_WIDTH-1:0]  cmd_reg,
   input  logic [DATA_WIDTH-1:0]      cmd_dat,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_dat,
   output logic                       rsp_we,
   output logic                       rsp_err,
   output logic [DATA_WIDTH-1:0]      ma_dat_o,
   output logic [SEL_WIDTH-1:0]       ma_sel_o,
   output logic [ADDR_WIDTH-1:0]      ma_addr_o,
   output logic                       ma_stb_o,
   output logic                       ma_cyc_o,
   output logic                       ma_we_o,
   input  logic [DATA_WIDTH-1:0]      ma_dat_i,
   input  logic                       ma_ack_i
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   state_e                  state_q;

   // Command FIFO storage and pointers
   logic                    fifo_we_q   [CMD_DEPTH];
   logic [ADDR_WIDTH-1:0]   fifo_addr_q [CMD_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_dat_q  [CMD_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        count_q;

   // Bus and response registers
   logic                    stb_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   dat_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_dat_q;
   logic                    rsp_we_q;
   logic                    rsp_err_q;

   logic                    push_s;
   logic                    pop_s;
   logic                    tmo_hit_s;

   assign cmd_ready = (count_q < CNT_W'(CMD_DEPTH));
   assign push_s    = cmd_valid && cmd_ready;
   assign pop_s     = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});

   // Command FIFO: pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < CMD_DEPTH; i++) begin
            fifo_we_q[i]   <= 1'b0;
            fifo_addr_q[i] <= {ADDR_WIDTH{1'b0}};
            fifo_dat_q[i]  <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (push_s) begin
            fifo_we_q[wr_ptr_q]   <= cmd_we;
            fifo_addr_q[wr_ptr_q] <= {cmd_type, cmd_port, cmd_reg};
            fifo_dat_q[wr_ptr_q]  <= cmd_dat;
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_q <= wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_q <= rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef WB_GPIO_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt_q;

   // The counter holds TIMEOUT_CYC-1 during the last permitted BUS cycle, so stb is high exactly TIMEOUT_CYC cycles
   assign tmo_hit_s = (state_q == ST_BUS) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

   // Ack timeout counter: cleared on BUS entry, counts every BUS cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q <= {TMO_W{1'b0}};
      end else if (pop_s) begin
         tmo_cnt_q <= {TMO_W{1'b0}};
      end else if (state_q == ST_BUS) begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end else begin
         tmo_cnt_q <= tmo_cnt_q;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Transfer FSM with registered bus and response outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         dat_q       <= {DATA_WIDTH{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= {DATA_WIDTH{1'b0}};
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop_s) begin
                  state_q <= ST_BUS;
                  stb_q   <= 1'b1;
                  we_q    <= fifo_we_q[rd_ptr_q];
                  addr_q  <= fifo_addr_q[rd_ptr_q];
                  dat_q   <= fifo_dat_q[rd_ptr_q];
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUS: begin
               // An ack on the timeout cycle takes priority over the timeout
               if (ma_ack_i) begin
                  state_q     <= ST_RSP;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= we_q ? {DATA_WIDTH{1'b0}} : ma_dat_i;
                  rsp_we_q    <= we_q;
                  rsp_err_q   <= 1'b0;
               end else if (tmo_hit_s) begin
                  state_q     <= ST_RSP;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= {DATA_WIDTH{1'b0}};
                  rsp_we_q    <= we_q;
                  rsp_err_q   <= 1'b1;
               end else begin
                  state_q <= ST_BUS;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end else begin
                  state_q <= ST_RSP;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               stb_q       <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ma_dat_o  = dat_q;
   assign ma_sel_o  = {SEL_WIDTH{1'b1}};
   assign ma_addr_o = addr_q;
   assign ma_stb_o  = stb_q;
   assign ma_cyc_o  = stb_q;
   assign ma_we_o   = we_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_gpio_master.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio_master
// Directed self-checking bench for wb_gpio_master. The slave model acks
// combinationally while stb is high and slv_run is set, and it keeps a
// register array indexed by the full address. spur_ack injects stray acks.
// -----------------------------------------------------------------------------
module tb_wb_gpio_master;

`ifdef WB_GPIO_MASTER_TIMEOUT_EN
   localparam int TB_TMO = 8;
`else
   localparam int TB_TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [4:0]  cmd_type;
   logic [4:0]  cmd_port;
   logic [4:0]  cmd_reg;
   logic [31:0] cmd_dat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_we;
   logic        rsp_err;
   logic [31:0] ma_dat_o;
   logic [3:0]  ma_sel_o;
   logic [14:0] ma_addr_o;
   logic        ma_stb_o;
   logic        ma_cyc_o;
   logic        ma_we_o;
   logic [31:0] ma_dat_i;
   logic        ma_ack_i;

   logic        slv_run;
   logic        spur_ack;
   logic [31:0] slv_mem [0:32767];

   int n_cmp = 0;
   int n_err = 0;

   wb_gpio_master #(.TIMEOUT_CYC(TB_TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_type  (cmd_type),
      .cmd_port  (cmd_port),
      .cmd_reg   (cmd_reg),
      .cmd_dat   (cmd_dat),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_we    (rsp_we),
      .rsp_err   (rsp_err),
      .ma_dat_o  (ma_dat_o),
      .ma_sel_o  (ma_sel_o),
      .ma_addr_o (ma_addr_o),
      .ma_stb_o  (ma_stb_o),
      .ma_cyc_o  (ma_cyc_o),
      .ma_we_o   (ma_we_o),
      .ma_dat_i  (ma_dat_i),
      .ma_ack_i  (ma_ack_i)
   );

   always #5 clk = ~clk;

   // Slave model: combinational ack and read data, writes land at the ack edge
   assign ma_ack_i = (ma_stb_o & ma_cyc_o & slv_run) | spur_ack;
   assign ma_dat_i = slv_mem[ma_addr_o];

   always @(posedge clk) begin
      if (ma_stb_o && ma_cyc_o && ma_we_o && slv_run)
         slv_mem[ma_addr_o] <= ma_dat_o;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic we, input logic [4:0] typ, input logic [4:0] port,
                           input logic [4:0] rg, input logic [31:0] dat);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_type  = typ;
      cmd_port  = port;
      cmd_reg   = rg;
      cmd_dat   = dat;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("push_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input logic exp_we, input logic [31:0] exp_dat,
                          input logic exp_err);
      int n;
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check_val({tag, "_we"},    {31'd0, rsp_we},    {31'd0, exp_we});
      check_val({tag, "_dat"},   rsp_dat,            exp_dat);
      check_val({tag, "_err"},   {31'd0, rsp_err},   {31'd0, exp_err});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic wait_stb(input string tag);
      int n;
      n = 0;
      while (!ma_stb_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, {31'd0, ma_stb_o}, 32'd1);
   endtask

   initial begin
      int lat;
      int cnt;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_type  = 5'd0;
      cmd_port  = 5'd0;
      cmd_reg   = 5'd0;
      cmd_dat   = 32'd0;
      rsp_ready = 1'b0;
      slv_run   = 1'b1;
      spur_ack  = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("rst_sel",       {28'd0, ma_sel_o}, 32'hF);
      check_val("rst_stb",       {31'd0, ma_stb_o}, 32'd0);
      check_val("rst_cyc",       {31'd0, ma_cyc_o}, 32'd0);
      check_val("rst_we",        {31'd0, ma_we_o},  32'd0);
      check_val("rst_addr",      {17'd0, ma_addr_o}, 32'd0);
      check_val("rst_dat",       ma_dat_o, 32'd0);
      check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_rsp_dat",   rsp_dat, 32'd0);
      check_val("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      reset = 1'b1;

      // ---- spurious ack while idle is ignored ----
      @(negedge clk);
      spur_ack = 1'b1;
      repeat (2) @(negedge clk);
      spur_ack = 1'b0;
      check_val("spur_idle_rsp", {31'd0, rsp_valid}, 32'd0);
      check_val("spur_idle_stb", {31'd0, ma_stb_o}, 32'd0);

      // ---- write IO port 0 DIR ----
      push_cmd(1'b1, 5'd0, 5'd0, 5'd0, 32'h0000FFFF);
      @(negedge clk);
      check_val("dir_pop_stb", {31'd0, ma_stb_o}, 32'd0);
      @(negedge clk);
      check_val("dir_stb",  {31'd0, ma_stb_o}, 32'd1);
      check_val("dir_cyc",  {31'd0, ma_cyc_o}, 32'd1);
      check_val("dir_we",   {31'd0, ma_we_o},  32'd1);
      check_val("dir_addr", {17'd0, ma_addr_o}, 32'h0000);
      check_val("dir_dat",  ma_dat_o, 32'h0000FFFF);
      check_val("dir_sel",  {28'd0, ma_sel_o}, 32'hF);
      @(negedge clk);
      check_val("dir_stb_low", {31'd0, ma_stb_o}, 32'd0);
      check_val("dir_rsp_v",   {31'd0, rsp_valid}, 32'd1);
      check_val("dir_rsp_we",  {31'd0, rsp_we}, 32'd1);
      check_val("dir_rsp_dat", rsp_dat, 32'd0);
      check_val("dir_mem",     slv_mem[15'h0000], 32'h0000FFFF);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check_val("dir_rsp_done", {31'd0, rsp_valid}, 32'd0);

      // ---- write then read O port 0 WRITE register (addr 0x801), latency 3 ----
      push_cmd(1'b1, 5'd2, 5'd0, 5'd1, 32'h000002A5);
      get_rsp("wr2a5", 1'b1, 32'd0, 1'b0);
      check_val("wr2a5_mem", slv_mem[15'h0801], 32'h000002A5);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_type  = 5'd2;
      cmd_port  = 5'd0;
      cmd_reg   = 5'd1;
      cmd_dat   = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("rd_latency", lat, 32'd3);
      get_rsp("rd2a5", 1'b0, 32'h000002A5, 1'b0);

      // ---- 5 commands with stalled slave: FIFO fills, then in-order completion ----
      slv_run = 1'b0;
      push_cmd(1'b1, 5'd0, 5'd3, 5'd1, 32'h11111111);
      push_cmd(1'b1, 5'd2, 5'd4, 5'd1, 32'h22222222);
      push_cmd(1'b0, 5'd0, 5'd3, 5'd1, 32'h0);
      push_cmd(1'b0, 5'd2, 5'd4, 5'd1, 32'h0);
      push_cmd(1'b1, 5'd1, 5'd1, 5'd0, 32'h33333333);
      @(negedge clk);
      check_val("full_ready", {31'd0, cmd_ready}, 32'd0);
      check_val("full_stb",   {31'd0, ma_stb_o}, 32'd1);
      check_val("full_addr",  {17'd0, ma_addr_o}, 32'h0061);
      check_val("full_dat",   ma_dat_o, 32'h11111111);
      slv_run = 1'b1;
      get_rsp("q0", 1'b1, 32'd0, 1'b0);
      get_rsp("q1", 1'b1, 32'd0, 1'b0);
      get_rsp("q2", 1'b0, 32'h11111111, 1'b0);
      get_rsp("q3", 1'b0, 32'h22222222, 1'b0);
      get_rsp("q4", 1'b1, 32'd0, 1'b0);
      check_val("q4_mem", slv_mem[15'h0420], 32'h33333333);

      // ---- response backpressure: hold rsp_ready low for 10 cycles ----
      push_cmd(1'b0, 5'd2, 5'd4, 5'd1, 32'h0);
      push_cmd(1'b1, 5'd0, 5'd7, 5'd2, 32'h44444444);
      @(negedge clk);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 10; i++) begin
         spur_ack = (i >= 3 && i < 6);
         check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check_val("hold_dat",   rsp_dat, 32'h22222222);
         check_val("hold_stb",   {31'd0, ma_stb_o}, 32'd0);
         @(negedge clk);
      end
      spur_ack = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      get_rsp("after_hold", 1'b1, 32'd0, 1'b0);
      check_val("after_hold_mem", slv_mem[15'h00E2], 32'h44444444);

`ifdef WB_GPIO_MASTER_TIMEOUT_EN
      // ---- ack timeout ----
      slv_run = 1'b0;
      push_cmd(1'b0, 5'd1, 5'd2, 5'd2, 32'h0);
      @(negedge clk);
      wait_stb("tmo_stb_seen");
      cnt = 0;
      while (ma_stb_o && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      check_val("tmo_stb_cycles", cnt, 32'd8);
      check_val("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("tmo_rsp_err",   {31'd0, rsp_err}, 32'd1);
      check_val("tmo_rsp_dat",   rsp_dat, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      slv_run = 1'b1;
`endif

      // ---- reset mid-transfer ----
      slv_run = 1'b0;
      push_cmd(1'b1, 5'd0, 5'd5, 5'd1, 32'h55555555);
      push_cmd(1'b1, 5'd0, 5'd6, 5'd1, 32'h66666666);
      @(negedge clk);
      wait_stb("rst_bus_stb");
      #2;
      reset = 1'b0;
      #1;
      check_val("arst_stb",   {31'd0, ma_stb_o}, 32'd0);
      check_val("arst_cyc",   {31'd0, ma_cyc_o}, 32'd0);
      check_val("arst_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("arst_rsp",   {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      reset   = 1'b1;
      slv_run = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ma_stb_o || rsp_valid) cnt++;
      end
      check_val("arst_queue_lost", cnt, 32'd0);
      push_cmd(1'b1, 5'd0, 5'd9, 5'd1, 32'h77777777);
      get_rsp("post_rst", 1'b1, 32'd0, 1'b0);
      check_val("post_rst_mem", slv_mem[15'h0121], 32'h77777777);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_gpio_master.md
Name: wb_gpio_master

Overview:
Wishbone single-transfer master that drives the GPIO slave register map (dir/write/read per port, addressed as {type,port,reg}).
- Buffers host commands in a small FIFO.
- Issues one classic-cycle transfer at a time and waits for ack.
- Returns read data and status through a response handshake.
- Sits between a CPU-less controller (test sequencer, NoC packet handler) and the GPIO slave.

Parameters:
DATA_WIDTH, 32, Wishbone data width.
SEL_WIDTH, 4, byte-select width; always driven all-ones.
ADDR_TYPE_WIDTH, 5, address field: port type (0 = IO, 1 = I, 2 = O).
ADDR_PORT_WIDTH, 5, address field: port index.
ADDR_REG_WIDTH, 5, address field: register (0 = DIR, 1 = WRITE, 2 = READ).
ADDR_WIDTH, ADDR_TYPE_WIDTH+ADDR_PORT_WIDTH+ADDR_REG_WIDTH, full address width.
CMD_DEPTH, 4, command FIFO depth; power of 2, ≥2.
TIMEOUT_CYC, 255, ack timeout in cycles; used only with the optional feature.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  host command present.
cmd_ready  out  1  FIFO not full.
cmd_we  in  1  1 = write, 0 = read.
cmd_type  in  ADDR_TYPE_WIDTH  port type field.
cmd_port  in  ADDR_PORT_WIDTH  port index field.
cmd_reg  in  ADDR_REG_WIDTH  register field.
cmd_dat  in  DATA_WIDTH  write data; ignored for reads.
rsp_valid  out  1  response available.
rsp_ready  in  1  host accepts response.
rsp_dat  out  DATA_WIDTH  read data; 0 for writes.
rsp_we  out  1  echo of the command's we.
rsp_err  out  1  transfer timed out (optional feature only; otherwise tied 0).
ma_dat_o  out  DATA_WIDTH  Wishbone write data.
ma_sel_o  out  SEL_WIDTH  byte selects; all ones.
ma_addr_o  out  ADDR_WIDTH  {type,port,reg}.
ma_stb_o  out  1  strobe.
ma_cyc_o  out  1  cycle; equals ma_stb_o.
ma_we_o  out  1  write enable.
ma_dat_i  in  DATA_WIDTH  read data from slave.
ma_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (reset = 0, async):
  - FIFO empty; FSM in IDLE.
  - All outputs 0, except cmd_ready = 1 and ma_sel_o = all ones.
- Command FIFO:
  - Push on cmd_valid && cmd_ready.
  - Pop when IDLE && FIFO non-empty.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - cmd_ready = (count < CMD_DEPTH), registered-free combinational.
  - Pointers wrap modulo CMD_DEPTH; count is log2(CMD_DEPTH)+1 bits.
- FSM states: IDLE, BUS, RSP.
  - IDLE → BUS on pop. Next cycle ma_stb_o = ma_cyc_o = 1, with addr/we/dat registered from the FIFO head.
  - BUS: hold all bus outputs stable until ma_ack_i = 1. On ack, in the same cycle:
    - deassert ma_stb_o/ma_cyc_o (registered, so low next cycle);
    - capture ma_dat_i into rsp_dat for reads, or 0 for writes;
    - go to RSP.
  - RSP: rsp_valid = 1 and all rsp fields held stable. On rsp_ready → IDLE.
- Slave ack arrives ≥1 cycle after stb. Minimum command-to-response latency from cmd push: 1 (pop) + 1 (stb) + 1 (ack) = rsp_valid on cycle 3.
- Strictly one outstanding transfer; no pipelining.
- A spurious ma_ack_i while not in BUS is ignored.
- A reset assertion mid-transfer aborts it: stb drops immediately and all queued commands are lost.

Optional Feature:
Macro: WB_GPIO_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on BUS entry and increments each BUS cycle.
  - If the counter reaches TIMEOUT_CYC with no ack: drop stb, go to RSP with rsp_err = 1 and rsp_dat = 0.
  - An ack on the same cycle as the timeout wins (rsp_err = 0).
- Undefined: no counter; BUS waits indefinitely; rsp_err is tied 0.

Test Plan:
- Write IO port 0 DIR: cmd {we=1, type=0, port=0, reg=0, dat=0x0000FFFF} → one stb cycle with addr 0x0000 and dat 0xFFFF, ack, then rsp_valid with rsp_we = 1, rsp_dat = 0.
- Read O port 0 WRITE register after writing 0x2A5 → rsp_dat = 0x2A5, rsp_we = 0; rsp_valid first seen 3 cycles after the read push.
- Push 5 commands back-to-back with CMD_DEPTH = 4 and the slave stalled → cmd_ready low after the 4th buffered command; all 5 complete in order once the slave runs.
- Hold rsp_ready = 0 for 10 cycles → rsp_valid and rsp_dat stable, ma_stb_o = 0, no new bus cycle until accepted.
- With WB_GPIO_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 8, and ack tied 0 → stb high exactly 8 cycles, then rsp_err = 1, rsp_dat = 0.
- Drive reset low while in BUS → ma_stb_o = 0 asynchronously, cmd_ready = 1, rsp_valid = 0; the next command runs normally after release.
